handshake_transmitter: RTL and testbench

//  Sending end of the 8-bit four-phase req/ack parallel link (o_dados/o_req out, i_ack in).

---
 rtl/handshake_transmitter.sv | 171 +++++++++++++++++
 tb/tb_handshake_transmitter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_transmitter.sv
// ---------------------------------------------------------------------------
// handshake_transmitter
//
// Sending end of the 8-bit four-phase req/ack parallel link. One byte at a
// time is taken from local logic over a valid/ready pair and presented to the
// remote receiver with this sequence: data, setup delay, req up, ack up,
// req down, ack down. On the controller board it carries PWM duty commands to
// the filtering FPGA. A dead or stuck link is detected with an ack timeout,
// and the FSM always returns to IDLE.
//
// Parameters
//   SETUP_CYCLES    clocks o_dados is stable before o_req rises (1..255)
//   SYNC_STAGES     flip-flop stages on i_ack ahead of the FSM (2..4)
//   TIMEOUT_CYCLES  max clocks in either ack phase; 0 disables the timeout
//
// Ports
//   clk_fpga        in   1  system clock, rising edge
//   reset           in   1  synchronous, active-high reset
//   i_dado_tx       in   8  byte to send, sampled when i_enviar & o_pronto
//   i_enviar        in   1  local valid
//   o_pronto        out  1  local ready, high only in IDLE
//   o_dados         out  8  link data bus
//   o_req           out  1  link request (registered)
//   i_ack           in   1  link acknowledge (asynchronous)
//   o_concluido     out  1  1-cycle pulse: transfer completed cleanly
//   o_erro_timeout  out  1  1-cycle pulse: ack timeout occurred
// ---------------------------------------------------------------------------
module handshake_transmitter #(
    parameter int SETUP_CYCLES   = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk_fpga,
    input  logic       reset,
    input  logic [7:0] i_dado_tx,
    input  logic       i_enviar,
    output logic       o_pronto,
    output logic [7:0] o_dados,
    output logic       o_req,
    input  logic       i_ack,
    output logic       o_concluido,
    output logic       o_erro_timeout
);

    localparam int CNT_MAX = (SETUP_CYCLES > TIMEOUT_CYCLES) ? SETUP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
    // The setup counter runs 0..SETUP_CYCLES, so o_req is first high
    // SETUP_CYCLES+1 edges after the capture edge.
    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES);
    localparam bit               TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT_ACK_H,
        S_WAIT_ACK_L
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [7:0]       dados_nxt;
    logic             req_nxt;
    logic             concluido_nxt;
    logic             erro_nxt;
    logic             timed_out, timed_out_nxt;   // this transfer already had a timeout
    logic             timeout_hit;

    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;

    assign ack_s    = ack_sync[SYNC_STAGES-1];
    assign o_pronto = (state == S_IDLE);

    // Counters saturate instead of wrapping.
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            o_dados        <= 8'h00;
            o_req          <= 1'b0;
            o_concluido    <= 1'b0;
            o_erro_timeout <= 1'b0;
            timed_out      <= 1'b0;
            ack_sync       <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            o_dados        <= dados_nxt;
            o_req          <= req_nxt;
            o_concluido    <= concluido_nxt;
            o_erro_timeout <= erro_nxt;
            timed_out      <= timed_out_nxt;
            ack_sync       <= {ack_sync[SYNC_STAGES-2:0], i_ack};
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        dados_nxt     = o_dados;
        req_nxt       = o_req;
        concluido_nxt = 1'b0;
        erro_nxt      = 1'b0;
        timed_out_nxt = timed_out;
        timeout_hit   = TIMEOUT_EN && (cnt == TIMEOUT_LAST);

        case (state)
            S_IDLE: begin
                if (i_enviar) begin
                    dados_nxt     = i_dado_tx;
                    cnt_nxt       = '0;
                    timed_out_nxt = 1'b0;
                    state_nxt     = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    req_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_WAIT_ACK_H;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_WAIT_ACK_H: begin
                // A stale ack already high on entry is accepted as the ack.
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = S_WAIT_ACK_L;
                end else if (timeout_hit) begin
                    req_nxt       = 1'b0;
                    erro_nxt      = 1'b1;
                    timed_out_nxt = 1'b1;
                    cnt_nxt       = '0;
                    state_nxt     = S_WAIT_ACK_L;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_WAIT_ACK_L: begin
                if (!ack_s) begin
                    // A transfer that already timed out never reports completion.
                    concluido_nxt = !timed_out;
                    cnt_nxt       = '0;
                    state_nxt     = S_IDLE;
                end else if (timeout_hit) begin
                    // ack is still stuck high here; give up and go idle.
                    erro_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_handshake_transmitter.sv
// ---------------------------------------------------------------------------
// tb_handshake_transmitter
//
// Self-checking bench for handshake_transmitter. A receiver model drives
// i_ack (responsive: ack = req delayed 3 clocks, dead: 0, stuck: 1), and a
// monitor records every byte present when o_req rises, o_req pulse lengths,
// data changes while o_req is high, and the completion/error pulses. The
// expected values come from the link rules: setup latency, timeout length,
// and the ordered list of bytes that should cross the link.
// ---------------------------------------------------------------------------
module tb_handshake_transmitter;

    localparam int SETUP = 2;
    localparam int SYNC  = 2;
    localparam int TMO   = 16;

    logic       clk_fpga = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] i_dado_tx = 8'h00;
    logic       i_enviar = 1'b0;
    logic       i_ack    = 1'b0;
    logic       o_pronto;
    logic [7:0] o_dados;
    logic       o_req;
    logic       o_concluido;
    logic       o_erro_timeout;

    handshake_transmitter #(
        .SETUP_CYCLES  (SETUP),
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_fpga      (clk_fpga),
        .reset         (reset),
        .i_dado_tx     (i_dado_tx),
        .i_enviar      (i_enviar),
        .o_pronto      (o_pronto),
        .o_dados       (o_dados),
        .o_req         (o_req),
        .i_ack         (i_ack),
        .o_concluido   (o_concluido),
        .o_erro_timeout(o_erro_timeout)
    );

    always #5 clk_fpga = ~clk_fpga;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- receiver model ----------------
    typedef enum {RX_RESP, RX_DEAD, RX_STUCK} rx_mode_t;
    rx_mode_t   rx_mode  = RX_RESP;
    logic [2:0] req_hist = 3'b000;

    always @(negedge clk_fpga) begin
        req_hist = {req_hist[1:0], o_req};
        case (rx_mode)
            RX_RESP:  i_ack = req_hist[2];
            RX_DEAD:  i_ack = 1'b0;
            default:  i_ack = 1'b1;
        endcase
    end

    // ---------------- link monitor ----------------
    logic [7:0] sent_q[$];
    logic [7:0] rise_dados    = 8'h00;
    logic       prev_req      = 1'b0;
    int         req_len       = 0;
    int         last_req_len  = 0;
    int         dados_changes = 0;
    int         concl_cnt     = 0;
    int         erro_cnt      = 0;

    always @(negedge clk_fpga) begin
        if (o_req && !prev_req) begin
            sent_q.push_back(o_dados);
            rise_dados = o_dados;
            req_len    = 0;
        end
        if (o_req) begin
            req_len++;
            if (o_dados !== rise_dados) dados_changes++;
        end
        if (!o_req && prev_req) last_req_len = req_len;
        if (o_concluido === 1'b1)    concl_cnt++;
        if (o_erro_timeout === 1'b1) erro_cnt++;
        prev_req = o_req;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic send_pulse(input logic [7:0] d);
        @(negedge clk_fpga);
        i_dado_tx = d;
        i_enviar  = 1'b1;
        @(posedge clk_fpga);
        #1 i_enviar = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_fpga);
            if (o_pronto === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk_fpga);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset    = 1'b1;
        i_enviar = 1'b0;
        repeat (3) @(posedge clk_fpga);
        @(negedge clk_fpga);
        n_checks++; if (o_pronto !== 1'b1) $display("FAIL reset_pronto got %b want 1", o_pronto); else n_pass++;
        n_checks++; if (o_req !== 1'b0) $display("FAIL reset_req got %b want 0", o_req); else n_pass++;
        n_checks++; if (o_dados !== 8'h00) $display("FAIL reset_dados got %h want 00", o_dados); else n_pass++;
        n_checks++; if (o_concluido !== 1'b0) $display("FAIL reset_concluido got %b want 0", o_concluido); else n_pass++;
        n_checks++; if (o_erro_timeout !== 1'b0) $display("FAIL reset_erro got %b want 0", o_erro_timeout); else n_pass++;
        reset = 1'b0;
        settle();
    endtask

    task automatic test_single();
        int base_c, base_e, base_s, edges;
        bit ok;
        rx_mode = RX_RESP;
        base_c = concl_cnt; base_e = erro_cnt; base_s = sent_q.size();
        send_pulse(8'hA5);
        @(negedge clk_fpga);
        n_checks++; if (o_dados !== 8'hA5) $display("FAIL single_capture got %h want a5", o_dados); else n_pass++;
        n_checks++; if (o_pronto !== 1'b0) $display("FAIL single_busy got %b want 0", o_pronto); else n_pass++;
        edges = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_fpga);
            if (o_req === 1'b1) begin
                edges = k;
                break;
            end
        end
        n_checks++; if (edges != SETUP + 1) $display("FAIL single_setup_edges got %0d want %0d", edges, SETUP + 1); else n_pass++;
        wait_idle(100, ok);
        settle();
        n_checks++; if (!ok) $display("FAIL single_done got timeout want idle"); else n_pass++;
        n_checks++; if (concl_cnt - base_c != 1) $display("FAIL single_concluido got %0d want 1", concl_cnt - base_c); else n_pass++;
        n_checks++; if (erro_cnt - base_e != 0) $display("FAIL single_erro got %0d want 0", erro_cnt - base_e); else n_pass++;
        n_checks++; if (o_pronto !== 1'b1) $display("FAIL single_pronto got %b want 1", o_pronto); else n_pass++;
        n_checks++; if (sent_q.size() - base_s != 1) $display("FAIL single_count got %0d want 1", sent_q.size() - base_s); else n_pass++;
        n_checks++; if (sent_q[sent_q.size()-1] !== 8'hA5) $display("FAIL single_byte got %h want a5", sent_q[sent_q.size()-1]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[$];
        int base_c, base_e, base_s, base_chg, idx, gaps;
        bit done;
        rx_mode = RX_RESP;
        bytes = '{8'h00, 8'hFF, 8'h3C};
        bytes.push_back(8'($urandom));
        bytes.push_back(8'($urandom));
        base_c = concl_cnt; base_e = erro_cnt; base_s = sent_q.size(); base_chg = dados_changes;
        idx = 0; gaps = 0; done = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk_fpga);
            if (o_pronto === 1'b1) begin
                if (idx < bytes.size()) begin
                    if (idx > 0) gaps++;
                    i_dado_tx = bytes[idx];
                    i_enviar  = 1'b1;
                    idx++;
                end else begin
                    i_enviar = 1'b0;
                    done     = 1'b1;
                    break;
                end
            end
        end
        i_enviar = 1'b0;
        settle();
        n_checks++; if (!done) $display("FAIL b2b_done got timeout want all sent"); else n_pass++;
        n_checks++; if (concl_cnt - base_c != bytes.size()) $display("FAIL b2b_concluido got %0d want %0d", concl_cnt - base_c, bytes.size()); else n_pass++;
        n_checks++; if (erro_cnt - base_e != 0) $display("FAIL b2b_erro got %0d want 0", erro_cnt - base_e); else n_pass++;
        n_checks++; if (dados_changes - base_chg != 0) $display("FAIL b2b_stable got %0d changes want 0", dados_changes - base_chg); else n_pass++;
        n_checks++; if (gaps != bytes.size() - 1) $display("FAIL b2b_gap_cycles got %0d want %0d", gaps, bytes.size() - 1); else n_pass++;
        n_checks++; if (sent_q.size() - base_s != bytes.size()) $display("FAIL b2b_count got %0d want %0d", sent_q.size() - base_s, bytes.size()); else n_pass++;
        for (int i = 0; i < bytes.size(); i++) begin
            n_checks++;
            if (sent_q[base_s + i] !== bytes[i]) $display("FAIL b2b_byte%0d got %h want %h", i, sent_q[base_s + i], bytes[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] d;
        int base_s, base_c;
        bit ok, all_ok;
        rx_mode = RX_RESP;
        base_s = sent_q.size(); base_c = concl_cnt; all_ok = 1'b1;
        for (int t = 0; t < 6; t++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk_fpga);
            d = 8'($urandom);
            exp_q.push_back(d);
            send_pulse(d);
            wait_idle(100, ok);
            all_ok &= ok;
        end
        settle();
        n_checks++; if (!all_ok) $display("FAIL rand_done got timeout want idle"); else n_pass++;
        n_checks++; if (concl_cnt - base_c != exp_q.size()) $display("FAIL rand_concluido got %0d want %0d", concl_cnt - base_c, exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (sent_q[base_s + i] !== exp_q[i]) $display("FAIL rand_byte%0d got %h want %h", i, sent_q[base_s + i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_dead_receiver();
        int base_c, base_e;
        bit ok;
        rx_mode = RX_DEAD;
        base_c = concl_cnt; base_e = erro_cnt;
        send_pulse(8'h5A);
        wait_idle(200, ok);
        settle();
        n_checks++; if (!ok) $display("FAIL dead_idle got timeout want idle"); else n_pass++;
        n_checks++; if (last_req_len != TMO) $display("FAIL dead_req_len got %0d want %0d", last_req_len, TMO); else n_pass++;
        n_checks++; if (erro_cnt - base_e != 1) $display("FAIL dead_erro got %0d want 1", erro_cnt - base_e); else n_pass++;
        n_checks++; if (concl_cnt - base_c != 0) $display("FAIL dead_concluido got %0d want 0", concl_cnt - base_c); else n_pass++;
        n_checks++; if (o_pronto !== 1'b1) $display("FAIL dead_pronto got %b want 1", o_pronto); else n_pass++;
    endtask

    task automatic test_stuck_ack();
        int base_c, base_e;
        bit ok;
        rx_mode = RX_STUCK;
        repeat (4) @(negedge clk_fpga);
        base_c = concl_cnt; base_e = erro_cnt;
        send_pulse(8'hC3);
        wait_idle(200, ok);
        settle();
        n_checks++; if (!ok) $display("FAIL stuck_idle got timeout want idle"); else n_pass++;
        n_checks++; if (last_req_len != 1) $display("FAIL stuck_req_len got %0d want 1", last_req_len); else n_pass++;
        n_checks++; if (erro_cnt - base_e != 1) $display("FAIL stuck_erro got %0d want 1", erro_cnt - base_e); else n_pass++;
        n_checks++; if (concl_cnt - base_c != 0) $display("FAIL stuck_concluido got %0d want 0", concl_cnt - base_c); else n_pass++;
        n_checks++; if (o_pronto !== 1'b1) $display("FAIL stuck_pronto got %b want 1", o_pronto); else n_pass++;
        rx_mode = RX_RESP;
        repeat (6) @(negedge clk_fpga);
    endtask

    task automatic test_reset_mid_transfer();
        int base_c, base_e;
        bit ok;
        rx_mode = RX_DEAD;
        base_e = erro_cnt;
        send_pulse(8'h99);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_fpga);
            if (o_req === 1'b1) break;
        end
        repeat (3) @(negedge clk_fpga);
        n_checks++; if (o_req !== 1'b1) $display("FAIL rstmid_pre_req got %b want 1", o_req); else n_pass++;
        reset = 1'b1;
        @(posedge clk_fpga);
        #1 reset = 1'b0;
        @(negedge clk_fpga);
        n_checks++; if (o_req !== 1'b0) $display("FAIL rstmid_req got %b want 0", o_req); else n_pass++;
        n_checks++; if (o_dados !== 8'h00) $display("FAIL rstmid_dados got %h want 00", o_dados); else n_pass++;
        n_checks++; if (o_pronto !== 1'b1) $display("FAIL rstmid_pronto got %b want 1", o_pronto); else n_pass++;
        rx_mode = RX_RESP;
        repeat (4) @(negedge clk_fpga);
        base_c = concl_cnt;
        send_pulse(8'h11);
        wait_idle(100, ok);
        settle();
        n_checks++; if (!ok) $display("FAIL rstmid_resend got timeout want idle"); else n_pass++;
        n_checks++; if (concl_cnt - base_c != 1) $display("FAIL rstmid_concluido got %0d want 1", concl_cnt - base_c); else n_pass++;
        n_checks++; if (erro_cnt - base_e != 0) $display("FAIL rstmid_erro got %0d want 0", erro_cnt - base_e); else n_pass++;
        n_checks++; if (sent_q[sent_q.size()-1] !== 8'h11) $display("FAIL rstmid_byte got %h want 11", sent_q[sent_q.size()-1]); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int base_s, base_c, seen77;
        bit ok;
        rx_mode = RX_RESP;
        base_s = sent_q.size(); base_c = concl_cnt; seen77 = 0;
        send_pulse(8'h22);
        repeat (4) @(negedge clk_fpga);
        n_checks++; if (o_pronto !== 1'b0) $display("FAIL busy_pre_pronto got %b want 0", o_pronto); else n_pass++;
        i_dado_tx = 8'h77;
        i_enviar  = 1'b1;
        @(posedge clk_fpga);
        #1 i_enviar = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_fpga);
            if (o_dados === 8'h77) seen77++;
            if (o_pronto === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        settle();
        n_checks++; if (!ok) $display("FAIL busy_done got timeout want idle"); else n_pass++;
        n_checks++; if (seen77 != 0) $display("FAIL busy_77_seen got %0d cycles want 0", seen77); else n_pass++;
        n_checks++; if (o_dados !== 8'h22) $display("FAIL busy_dados got %h want 22", o_dados); else n_pass++;
        n_checks++; if (sent_q.size() - base_s != 1) $display("FAIL busy_count got %0d want 1", sent_q.size() - base_s); else n_pass++;
        n_checks++; if (concl_cnt - base_c != 1) $display("FAIL busy_concluido got %0d want 1", concl_cnt - base_c); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_dead_receiver();
        test_stuck_ack();
        test_reset_mid_transfer();
        test_busy_ignore();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
